reflect_checker: RTL and testbench

Receive-side checker for the free-running 8-bit incrementing stream produced by the reflect counter. It samples the stream, locks onto the +1-per-sample sequence, and flags, counts and tolerates sequence breaks. It sits at the consumer end of the link as a loopback/integrity monitor. It exposes lock status, single-cycle error pulses and saturating good/error counters to the surrounding testbench or status logic.

---
 rtl/reflect_checker_if.sv | 25 ++
 rtl/reflect_checker.sv | 121 ++++++++++++
 tb/tb_reflect_checker.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/reflect_checker_if.sv
// Stream-side bundle between the sample source and reflect_checker.
// The source drives the sample and clear; the checker returns status and counters.
interface reflect_checker_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             clr_counts;
  logic             locked;
  logic             error;
  logic [CNT_W-1:0] good_count;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  modport master (
    output in, in_valid, clr_counts,
    input  locked, error, good_count, err_count, expected
  );

  modport slave (
    input  in, in_valid, clr_counts,
    output locked, error, good_count, err_count, expected
  );
endinterface

// File: rtl/reflect_checker.sv
// Receive-side checker for a +1-per-sample stream: locks after a run of matches,
// pulses and counts breaks while locked, and drops lock after a run of misses.
module reflect_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  reflect_checker_if.slave    bus
);

  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W = $clog2(LOSS_COUNT + 1);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t            r_state,     w_state_nxt;
  logic [WIDTH-1:0]  r_prev,      w_prev_nxt;
  logic              r_have_prev, w_have_prev_nxt;
  logic [RUN_W-1:0]  r_run,       w_run_nxt;
  logic [MISS_W-1:0] r_miss,      w_miss_nxt;
  logic              r_error,     w_error_nxt;
  logic [CNT_W-1:0]  r_good,      w_good_nxt;
  logic [CNT_W-1:0]  r_errc,      w_errc_nxt;
  logic [WIDTH-1:0]  r_expected,  w_expected_nxt;
  logic              w_match;

  assign w_match = r_have_prev && (bus.in == WIDTH'(r_prev + WIDTH'(1)));

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_run       <= '0;
      r_miss      <= '0;
      r_error     <= 1'b0;
      r_good      <= '0;
      r_errc      <= '0;
      r_expected  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= w_prev_nxt;
      r_have_prev <= w_have_prev_nxt;
      r_run       <= w_run_nxt;
      r_miss      <= w_miss_nxt;
      r_error     <= w_error_nxt;
      r_good      <= w_good_nxt;
      r_errc      <= w_errc_nxt;
      r_expected  <= w_expected_nxt;
    end
  end

  // Next-state and counter updates
  always_comb begin
    w_state_nxt     = r_state;
    w_prev_nxt      = r_prev;
    w_have_prev_nxt = r_have_prev;
    w_run_nxt       = r_run;
    w_miss_nxt      = r_miss;
    w_error_nxt     = 1'b0;
    w_good_nxt      = r_good;
    w_errc_nxt      = r_errc;
    w_expected_nxt  = r_expected;

    if (bus.in_valid) begin
      w_prev_nxt      = bus.in;
      w_have_prev_nxt = 1'b1;
      w_expected_nxt  = WIDTH'(bus.in + WIDTH'(1));

      case (r_state)
        HUNT: begin
          if (w_match) begin
            if (32'(r_run) + 32'd1 == LOCK_COUNT) begin
              w_state_nxt = LOCK;
              w_run_nxt   = '0;
              w_miss_nxt  = '0;
            end else begin
              w_run_nxt = RUN_W'(r_run + RUN_W'(1));
            end
          end else begin
            w_run_nxt = '0;
          end
        end
        LOCK: begin
          if (w_match) begin
            w_miss_nxt = '0;
            if (r_good != '1) w_good_nxt = CNT_W'(r_good + CNT_W'(1));
          end else begin
            w_error_nxt = 1'b1;
            if (r_errc != '1) w_errc_nxt = CNT_W'(r_errc + CNT_W'(1));
            if (32'(r_miss) + 32'd1 == LOSS_COUNT) begin
              w_state_nxt = HUNT;
              w_run_nxt   = '0;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt = MISS_W'(r_miss + MISS_W'(1));
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end

    // Clear has priority over any same-cycle increment
    if (bus.clr_counts) begin
      w_good_nxt = '0;
      w_errc_nxt = '0;
    end
  end

  assign bus.locked     = (r_state == LOCK);
  assign bus.error      = r_error;
  assign bus.good_count = r_good;
  assign bus.err_count  = r_errc;
  assign bus.expected   = r_expected;

endmodule

// File: tb/tb_reflect_checker.sv
// Bench for reflect_checker: directed vector table, saturation/reset corner cases
// on a narrow-counter instance, then random traffic against a behavioural model.
module tb_reflect_checker;

  localparam int unsigned W      = 8;
  localparam int unsigned LOCK_N = 4;
  localparam int unsigned LOSS_N = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n_s;
  always #5 clk = ~clk;

  reflect_checker_if #(.WIDTH(8), .CNT_W(16)) bus   ();
  reflect_checker_if #(.WIDTH(8), .CNT_W(4))  bus_s ();

  reflect_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  reflect_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(2), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n_s), .bus(bus_s)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        c;
    logic        l;
    logic        e;
    logic [15:0] g;
    logic [15:0] er;
    logic [7:0]  x;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic v, logic [7:0] d, logic c, logic l, logic e,
                              logic [15:0] g, logic [15:0] er, logic [7:0] x);
    vec_t t;
    t.v = v; t.d = d; t.c = c; t.l = l; t.e = e; t.g = g; t.er = er; t.x = x;
    vq.push_back(t);
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    bus.in_valid = v; bus.in = d; bus.clr_counts = c;
    @(posedge clk); #1;
  endtask

  task automatic drive_s(input logic v, input logic [7:0] d, input logic c);
    bus_s.in_valid = v; bus_s.in = d; bus_s.clr_counts = c;
    @(posedge clk); #1;
  endtask

  // Behavioural reference for the random phase
  int m_prev, m_streak, m_misses, m_good, m_err, m_exp;
  bit m_have, m_locked, m_error;

  function automatic void model_reset();
    m_prev = 0; m_streak = 0; m_misses = 0; m_good = 0; m_err = 0; m_exp = 0;
    m_have = 0; m_locked = 0; m_error = 0;
  endfunction

  function automatic void model_step(bit v, int d, bit c);
    bit hit;
    m_error = 0;
    if (v) begin
      hit = m_have && (d == (m_prev + 1) % 256);
      if (!m_locked) begin
        if (hit) begin
          m_streak++;
          if (m_streak >= LOCK_N) begin m_locked = 1; m_streak = 0; m_misses = 0; end
        end else m_streak = 0;
      end else if (hit) begin
        if (m_good < 65535) m_good++;
        m_misses = 0;
      end else begin
        m_error = 1;
        if (m_err < 65535) m_err++;
        m_misses++;
        if (m_misses >= LOSS_N) begin m_locked = 0; m_streak = 0; m_misses = 0; end
      end
      m_prev = d; m_have = 1; m_exp = (d + 1) % 256;
    end
    if (c) begin m_good = 0; m_err = 0; end
  endfunction

  initial begin
    logic [7:0] p;
    bus.in_valid = 0; bus.in = 0; bus.clr_counts = 0;
    bus_s.in_valid = 0; bus_s.in = 0; bus_s.clr_counts = 0;
    rst_n = 0; rst_n_s = 0;

    // Vector table
    for (int i = 0; i < 10; i++) add(0, 8'h5A, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 2);
    add(1, 2, 0, 0, 0, 0, 0, 3);
    add(1, 3, 0, 0, 0, 0, 0, 4);
    add(1, 4, 0, 1, 0, 0, 0, 5);
    for (int i = 5; i <= 10; i++) add(1, 8'(i), 0, 1, 0, 16'(i - 4), 0, 8'(i + 1));
    add(1, 12, 0, 1, 1, 6, 1, 13);
    add(1, 13, 0, 1, 0, 7, 1, 14);
    add(1, 14, 0, 1, 0, 8, 1, 15);
    for (int i = 15; i <= 20; i++) add(1, 8'(i), 0, 1, 0, 16'(i - 6), 1, 8'(i + 1));
    add(1, 7,   0, 1, 1, 14, 2, 8);
    add(1, 99,  0, 0, 1, 14, 3, 100);
    add(1, 100, 0, 0, 0, 14, 3, 101);
    add(1, 101, 0, 0, 0, 14, 3, 102);
    add(1, 102, 0, 0, 0, 14, 3, 103);
    add(1, 103, 0, 1, 0, 14, 3, 104);
    add(1, 104, 0, 1, 0, 15, 3, 105);
    add(1, 252, 0, 1, 1, 15, 4, 253);
    add(1, 253, 0, 1, 0, 16, 4, 254);
    add(1, 254, 0, 1, 0, 17, 4, 255);
    add(1, 255, 0, 1, 0, 18, 4, 0);
    for (int i = 0; i < 3; i++) add(0, 8'h4D, 0, 1, 0, 18, 4, 0);
    add(1, 0, 0, 1, 0, 19, 4, 1);
    add(1, 1, 0, 1, 0, 20, 4, 2);
    add(1, 2, 1, 1, 0, 0, 0, 3);
    add(1, 3, 0, 1, 0, 1, 0, 4);
    add(0, 8'h11, 1, 1, 0, 0, 0, 4);

    #3;
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_good", 32'(bus.good_count), 0);
    check("rst_expected", 32'(bus.expected), 0);
    @(posedge clk); #1;
    rst_n = 1; rst_n_s = 1;

    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].d, vq[i].c);
      check($sformatf("vec%0d_locked", i),   32'(bus.locked),     32'(vq[i].l));
      check($sformatf("vec%0d_error", i),    32'(bus.error),      32'(vq[i].e));
      check($sformatf("vec%0d_good", i),     32'(bus.good_count), 32'(vq[i].g));
      check($sformatf("vec%0d_err", i),      32'(bus.err_count),  32'(vq[i].er));
      check($sformatf("vec%0d_expected", i), 32'(bus.expected),   32'(vq[i].x));
    end

    // Narrow counters: saturation, clear, clear-vs-increment, async reset
    for (int i = 0; i <= 4; i++) drive_s(1, 8'(i), 0);
    check("sat_lock", 32'(bus_s.locked), 1);
    p = 8'd4;
    for (int i = 0; i < 20; i++) begin
      p = 8'(p + 8'd2);
      drive_s(1, p, 0);
      check($sformatf("sat_err_pulse%0d", i), 32'(bus_s.error), 1);
      p = 8'(p + 8'd1);
      drive_s(1, p, 0);
    end
    check("sat_err_count", 32'(bus_s.err_count), 15);
    check("sat_good_count", 32'(bus_s.good_count), 15);
    check("sat_still_locked", 32'(bus_s.locked), 1);
    drive_s(0, 8'h33, 1);
    check("clr_err", 32'(bus_s.err_count), 0);
    check("clr_good", 32'(bus_s.good_count), 0);
    p = 8'(p + 8'd2);
    drive_s(1, p, 1);
    check("clr_wins_err", 32'(bus_s.err_count), 0);
    check("clr_wins_pulse", 32'(bus_s.error), 1);
    bus_s.in_valid = 0; bus_s.clr_counts = 0;
    rst_n_s = 0;
    #1;
    check("async_rst_locked", 32'(bus_s.locked), 0);
    check("async_rst_error", 32'(bus_s.error), 0);
    check("async_rst_expected", 32'(bus_s.expected), 0);

    // Random traffic against the model
    rst_n = 0;
    model_reset();
    #1;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 400; i++) begin
      bit v, c;
      int d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      d = ($urandom_range(0, 9) < 8) ? (m_prev + 1) % 256 : int'($urandom_range(0, 255));
      drive(v, 8'(d), c);
      model_step(v, d, c);
      check($sformatf("rnd%0d_locked", i),   32'(bus.locked),     32'(m_locked));
      check($sformatf("rnd%0d_error", i),    32'(bus.error),      32'(m_error));
      check($sformatf("rnd%0d_good", i),     32'(bus.good_count), 32'(m_good));
      check($sformatf("rnd%0d_err", i),      32'(bus.err_count),  32'(m_err));
      check($sformatf("rnd%0d_expected", i), 32'(bus.expected),   32'(m_exp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
